// File: rtl/controle_seq.sv
// controle_seq: start/busy/done sequencer for the register/ULA datapath.
// It walks through load-X, load-Y, an optional iterative divide phase,
// execute and store-Z, and drives the per-register control codes
// (Tx/Ty/Tz) and the ULA opcode (Tula).
// All outputs are registered from the next-state decode, so they always
// match the state that is held after the same rising edge.
// Optional macro CONTROLE_SEQ_LOOP_EN: when defined, a start seen in DONE
// chains straight into LOAD_X for back-to-back operations. When it is not
// defined, DONE always returns to IDLE.
module controle_seq #(
  parameter int CODE_W = 3,
  parameter int OP_W   = 4,
  parameter int DIV_OP = 3,
  parameter int ITER_N = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  output logic [CODE_W-1:0] Tx,
  output logic [CODE_W-1:0] Ty,
  output logic [CODE_W-1:0] Tz,
  output logic [OP_W-1:0]   Tula,
  output logic              busy,
  output logic              done
);

  // Register control codes.
  localparam logic [CODE_W-1:0] CODE_CLEAR = CODE_W'(0);
  localparam logic [CODE_W-1:0] CODE_LOAD  = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_HOLD  = CODE_W'(2);
  localparam logic [CODE_W-1:0] CODE_DIV   = CODE_W'(3);

  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(DIV_OP);
  localparam logic [OP_W-1:0] OP_ZERO = '0;

  // Value loaded into the counter on entering ITER. It is only used when
  // ITER_N > 0, so the wrap-around at ITER_N == 0 is never seen.
  localparam logic [7:0] ITER_LAST = 8'(ITER_N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_X  = 3'd1,
    S_LOAD_Y  = 3'd2,
    S_ITER    = 3'd3,
    S_EXEC    = 3'd4,
    S_STORE_Z = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_r_q, op_r_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] tx_q, tx_d;
  logic [CODE_W-1:0] ty_q, ty_d;
  logic [CODE_W-1:0] tz_q, tz_d;
  logic [OP_W-1:0]   tula_q, tula_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, opcode latch and counter update, then the output decode of
  // the state that is about to be entered.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. This keeps
    // the block purely combinational, so no latch is inferred on a path that
    // does not assign the signal.
    state_d = state_q;
    op_r_d  = op_r_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_r_d  = op;
          state_d = S_LOAD_X;
        end
      end
      S_LOAD_X: state_d = S_LOAD_Y;
      S_LOAD_Y: begin
        if (op_r_q == OP_DIV && ITER_N > 0) begin
          cnt_d   = ITER_LAST;
          state_d = S_ITER;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_ITER: begin
        if (cnt_q == 8'd0) begin
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_EXEC:    state_d = S_STORE_Z;
      S_STORE_Z: state_d = S_DONE;
      S_DONE: begin
`ifdef CONTROLE_SEQ_LOOP_EN
        if (start) begin
          op_r_d  = op;
          state_d = S_LOAD_X;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    tx_d   = CODE_HOLD;
    ty_d   = CODE_HOLD;
    tz_d   = CODE_HOLD;
    tula_d = OP_ZERO;
    busy_d = 1'b1;
    done_d = 1'b0;

    case (state_d)
      S_IDLE:   busy_d = 1'b0;
      S_LOAD_X: begin
        tx_d = CODE_LOAD;
        ty_d = CODE_CLEAR;
        tz_d = CODE_CLEAR;
      end
      S_LOAD_Y:  ty_d   = CODE_LOAD;
      S_ITER:    ty_d   = CODE_DIV;
      S_EXEC:    tula_d = op_r_d;
      S_STORE_Z: begin
        tz_d   = CODE_LOAD;
        tula_d = op_r_d;
      end
      S_DONE:    done_d = 1'b1;
      default:   busy_d = 1'b0;
    endcase
  end

  // State, latched opcode, iteration counter and registered outputs.
  // The synchronous reset takes priority over every transition.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the edge, whatever the order of
    // the statements.
    if (reset) begin
      state_q <= S_IDLE;
      op_r_q  <= OP_ZERO;
      cnt_q   <= 8'd0;
      tx_q    <= CODE_CLEAR;
      ty_q    <= CODE_CLEAR;
      tz_q    <= CODE_CLEAR;
      tula_q  <= OP_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_r_q  <= op_r_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tz_q    <= tz_d;
      tula_q  <= tula_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Tx   = tx_q;
  assign Ty   = ty_q;
  assign Tz   = tz_q;
  assign Tula = tula_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_controle_seq.sv
// Directed testbench for controle_seq. It uses the default parameters
// (ITER_N = 4, DIV_OP = 3). Each output vector is packed as
// {Tx, Ty, Tz, Tula, busy, done} and compared against a hand-derived value.
module tb_controle_seq;

  localparam int CODE_W = 3;
  localparam int OP_W   = 4;
  localparam int DIV_OP = 3;
  localparam int ITER_N = 4;
`ifdef CONTROLE_SEQ_LOOP_EN
  localparam int PERIOD = 5;
`else
  localparam int PERIOD = 6;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [OP_W-1:0]   op;
  logic [CODE_W-1:0] Tx, Ty, Tz;
  logic [OP_W-1:0]   Tula;
  logic              busy, done;
  logic [14:0]       obs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  controle_seq #(
    .CODE_W(CODE_W), .OP_W(OP_W), .DIV_OP(DIV_OP), .ITER_N(ITER_N)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .Tx(Tx), .Ty(Ty), .Tz(Tz), .Tula(Tula), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  assign obs = {Tx, Ty, Tz, Tula, busy, done};

  function automatic logic [14:0] vec(int x, int y, int z, int u, int b, int d);
    return {3'(x), 3'(y), 3'(z), 4'(u), 1'(b), 1'(d)};
  endfunction

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (obs !== vec(0, 0, 0, 0, 0, 0))
        $display("FAIL reset cycle %0d: got %h expected %h", i, obs, vec(0, 0, 0, 0, 0, 0));
      else pass_cnt++;
    end
    reset = 1'b0;
    tick();
    total_cnt++;
    if (obs !== vec(2, 2, 2, 0, 0, 0))
      $display("FAIL idle_after_reset: got %h expected %h", obs, vec(2, 2, 2, 0, 0, 0));
    else pass_cnt++;
  endtask

  // Plain operation with op=1. The sequence runs LOAD_X, LOAD_Y, EXEC,
  // STORE_Z, DONE and then returns to IDLE.
  task automatic run_plain(input string name, input int opv);
    logic [14:0] e[6];
    e = '{vec(1, 0, 0, 0, 1, 0), vec(2, 1, 2, 0, 1, 0), vec(2, 2, 2, opv, 1, 0),
          vec(2, 2, 1, opv, 1, 0), vec(2, 2, 2, 0, 1, 1), vec(2, 2, 2, 0, 0, 0)};
    op = 4'(opv); start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      total_cnt++;
      if (obs !== e[i])
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, e[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    run_plain("basic", 1);
  endtask

  // Divide operation. The sequence runs LOAD_X, LOAD_Y, four ITER cycles,
  // EXEC, STORE_Z, DONE (cycle 9) and then IDLE. When disturb is set, start
  // is pulsed with op=5 during the second ITER cycle, and that request must
  // be ignored.
  task automatic run_div(input string name, input bit disturb);
    logic [14:0] e[$];
    int done_seen = 0;
    e.push_back(vec(1, 0, 0, 0, 1, 0));
    e.push_back(vec(2, 1, 2, 0, 1, 0));
    for (int k = 0; k < ITER_N; k++) e.push_back(vec(2, 3, 2, 0, 1, 0));
    e.push_back(vec(2, 2, 2, 3, 1, 0));
    e.push_back(vec(2, 2, 1, 3, 1, 0));
    e.push_back(vec(2, 2, 2, 0, 1, 1));
    e.push_back(vec(2, 2, 2, 0, 0, 0));
    e.push_back(vec(2, 2, 2, 0, 0, 0));
    op = 4'(DIV_OP); start = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      tick();
      start = 1'b0;
      if (disturb && i == 3) begin start = 1'b1; op = 4'd5; end
      if (done === 1'b1) done_seen++;
      total_cnt++;
      if (obs !== e[i])
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, e[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_seen !== 1)
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_seen);
    else pass_cnt++;
  endtask

  task automatic test_div();
    run_div("div", 1'b0);
  endtask

  task automatic test_ignore_busy();
    run_div("ignore_busy", 1'b1);
  endtask

  // Reset is asserted during the second ITER cycle. After that, the sequencer
  // must return to reset values with no done pulse, and a fresh operation
  // must run normally.
  task automatic test_reset_mid();
    int done_seen = 0;
    op = 4'(DIV_OP); start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
    end
    total_cnt++;
    if (obs !== vec(2, 3, 2, 0, 1, 0))
      $display("FAIL reset_mid pre: got %h expected %h", obs, vec(2, 3, 2, 0, 1, 0));
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (obs !== vec(0, 0, 0, 0, 0, 0))
      $display("FAIL reset_mid values: got %h expected %h", obs, vec(0, 0, 0, 0, 0, 0));
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    total_cnt++;
    if (done_seen !== 0)
      $display("FAIL reset_mid quiet: got %0d active cycles expected 0", done_seen);
    else pass_cnt++;
    run_plain("after_reset", 1);
  endtask

  // Hold start high with op=2. With the loop option, the cycle runs LOAD_X,
  // LOAD_Y, EXEC, STORE_Z, DONE, repeated with no gap (period 5). Without
  // it, one IDLE cycle follows DONE (period 6).
  task automatic test_back_to_back();
    logic [14:0] e[6];
    int last_done = -1;
    int gap_err = 0;
    e = '{vec(1, 0, 0, 0, 1, 0), vec(2, 1, 2, 0, 1, 0), vec(2, 2, 2, 2, 1, 0),
          vec(2, 2, 1, 2, 1, 0), vec(2, 2, 2, 0, 1, 1), vec(2, 2, 2, 0, 0, 0)};
    op = 4'd2; start = 1'b1;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      tick();
      if (done === 1'b1) begin
        if (last_done >= 0 && i - last_done != PERIOD) gap_err++;
        last_done = i;
      end
      total_cnt++;
      if (obs !== e[i % PERIOD])
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, e[i % PERIOD]);
      else pass_cnt++;
    end
    start = 1'b0;
    total_cnt++;
    if (gap_err !== 0 || last_done !== 3 * PERIOD - PERIOD + 4)
      $display("FAIL back_to_back period: gap errors %0d last done %0d expected 0 and %0d",
               gap_err, last_done, 2 * PERIOD + 4);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (obs !== vec(2, 2, 2, 0, 0, 0))
      $display("FAIL back_to_back idle: got %h expected %h", obs, vec(2, 2, 2, 0, 0, 0));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/controle_seq.md
Name: controle_seq

Overview:
- Parametrised sequencer for the register/ULA datapath. Drives per-register control codes (Tx, Ty, Tz) and the ULA opcode (Tula) through a load-X, load-Y, execute, store-Z sequence.
- Adds what the fixed free-running controller lacks: start/busy/done handshake, a per-operation opcode, and an iterative divide mode with configurable step count.
- Sits between the top-level operation request and the X/Y/Z register files and ULA.

Parameters:
- CODE_W, 3, width of register control codes (min 2). Codes: CLEAR=0, LOAD=1, HOLD=2, DIV=3.
- OP_W, 4, width of ULA opcode.
- DIV_OP, 3, opcode value that selects iterative divide mode.
- ITER_N, 4, number of Ty=DIV cycles in divide mode (0..255; 0 = no iteration cycles).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  OP_W  ULA opcode; latched into op_r when start is accepted.
- Tx  output  CODE_W  control code for register X.
- Ty  output  CODE_W  control code for register Y.
- Tz  output  CODE_W  control code for register Z.
- Tula  output  OP_W  opcode presented to ULA.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- All outputs registered; they reflect the state held after the same rising edge (Moore, registered from next-state).
- Reset (sync, priority over everything): state=IDLE; Tx=Ty=Tz=CLEAR; Tula=0; busy=0; done=0; op_r=0; iteration counter=0.
- States and outputs (Tx/Ty/Tz, Tula):
- IDLE: HOLD/HOLD/HOLD, Tula=0, busy=0. start=1 -> latch op_r=op, go LOAD_X. Otherwise stay.
- LOAD_X: LOAD/CLEAR/CLEAR, Tula=0 -> LOAD_Y.
- LOAD_Y: HOLD/LOAD/HOLD, Tula=0. If op_r==DIV_OP and ITER_N>0 -> ITER with cnt=ITER_N-1. Otherwise -> EXEC.
- ITER: HOLD/DIV/HOLD, Tula=0. cnt==0 -> EXEC; else cnt-=1, stay. Exactly ITER_N cycles spent here.
- EXEC: HOLD/HOLD/HOLD, Tula=op_r -> STORE_Z.
- STORE_Z: HOLD/HOLD/LOAD, Tula=op_r -> DONE.
- DONE: HOLD/HOLD/HOLD, Tula=0, done=1 -> IDLE (see Optional Feature).
- Latency: start accepted at edge k; done high in cycle k+5 (non-DIV) or k+5+ITER_N (DIV).
- start while busy=1: ignored; op changes while busy: ignored, op_r stable.
- Reset mid-operation: next edge returns to IDLE with reset values; no done pulse.
- Counter width: 8 bits; ITER_N>255 is illegal.
- Unused encodings of the state register -> IDLE on next edge.

Optional Feature:
- Macro CONTROLE_SEQ_LOOP_EN.
- Defined: in DONE, if start=1, re-latch op_r=op and go directly to LOAD_X. busy stays 1, done still pulses for one cycle. This gives back-to-back operations, period 5 (+ITER_N) cycles, matching the free-running behaviour.
- Undefined: DONE always -> IDLE; a new start is accepted one cycle later at the earliest.

Test Plan:
- Assert reset 2 cycles -> Tx=Ty=Tz=0, Tula=0, busy=0, done=0. Deassert with start=0 -> IDLE outputs Tx=Ty=Tz=2.
- start=1 for one cycle with op=1 -> following cycles (Tx,Ty,Tz,Tula) = (1,0,0,0), (2,1,2,0), (2,2,2,1), (2,2,1,1), (2,2,2,0) with done=1, then busy=0.
- op=3 (DIV_OP), ITER_N=4 -> after LOAD_Y, exactly 4 cycles Ty=3, then EXEC Tula=3. done in cycle 9 after start.
- start pulsed and op changed to 5 during ITER -> no restart; Tula=3 in EXEC/STORE_Z; only one done pulse.
- reset asserted during second ITER cycle -> next cycle reset values, busy=0, no done. A fresh start afterwards completes normally.
- With CONTROLE_SEQ_LOOP_EN, start held at 1, op=2 -> done pulses every 5 cycles, LOAD_X follows DONE directly, busy never drops. Without the macro -> one IDLE cycle between operations, period 6.
